fetch_control: RTL

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/cpu_consts.sv | 5 +
 rtl/fetch_control.sv | 110 +++++++++++
 2 files changed

// File: rtl/cpu_consts.sv
// cpu_consts: shared fetch state encoding and instruction constants
package cpu_consts;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_control.sv
// fetch_control: single-outstanding instruction fetch FSM with redirect handling; optional FETCH_MISALIGN_CHECK_EN halts on misaligned redirects
module fetch_control
    import cpu_consts::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_instr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_instr_o,
    output logic [63:0] fetch_pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned_o
`endif
);
    fetch_state_t state_q, state_d;
    logic [63:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, fpc_d, rpc;
    logic [31:0] instr_d;
    logic        halt_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_d;
    assign fetch_misaligned_o = halt_q;
    assign rpc = redirect_pc_i;
`else
    assign halt_q = 1'b0;
    assign rpc = redirect_pc_i & ~64'd3;
`endif
    assign imem_req_valid_o = (state_q == REQ);
    assign fetch_valid_o    = (state_q == HOLD);
    assign imem_req_addr_o  = pc_q;
    // next state, next PC and output-register load; redirect wins everywhere except IDLE
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        instr_d  = fetch_instr_o;
        fpc_d    = fetch_pc_o;
        case (state_q)
            IDLE: state_d = halt_q ? IDLE : REQ;
            REQ: begin
                if (redirect_i) begin
                    pc_d    = rpc;
                    state_d = imem_req_ready_i ? DROP : REQ;
                end else if (imem_req_ready_i) begin
                    rsp_pc_d = pc_q;
                    pc_d     = pc_q + 64'd4;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d    = rpc;
                    state_d = imem_rsp_valid_i ? REQ : DROP;
                end else if (imem_rsp_valid_i) begin
                    instr_d = imem_rsp_instr_i;
                    fpc_d   = rsp_pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_i) pc_d = rpc;
                if (redirect_i || fetch_ready_i) state_d = REQ;
            end
            DROP: begin
                if (redirect_i) pc_d = rpc;
                if (imem_rsp_valid_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_d = halt_q;
        if (redirect_i && |redirect_pc_i[1:0] && state_q != IDLE) begin
            halt_d  = 1'b1;
            fpc_d   = redirect_pc_i;
            state_d = IDLE;
        end
`endif
    end
    // state, PC and decode-facing output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= 64'd0;
            fetch_instr_o <= NOP_INSTR;
            fetch_pc_o    <= 64'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            fetch_instr_o <= instr_d;
            fetch_pc_o    <= fpc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q        <= halt_d;
`endif
        end
    end
endmodule
